// File: rtl/fpu_cvtsw_wb_pkg.sv
// Shared FPU definitions: single-precision format constants, the common
// exception-flag layout, and the 2-entry writeback buffer state encoding.
package fpu_cvtsw_wb_pkg;

   localparam int SGL_NEXP = 8;
   localparam int SGL_NSIG = 23;
   localparam int SGL_BIAS = 127;
   localparam int SGL_EMAX = 127;

   // Flag vector shared by every FPU writeback stage, MSB first.
   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

   localparam logic [1:0] BUF_EMPTY = 2'd0;
   localparam logic [1:0] BUF_ONE   = 2'd1;
   localparam logic [1:0] BUF_FULL  = 2'd2;

endpackage

// File: rtl/fpu_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer. in_ready depends only on the
// registered occupancy, so upstream never sees a path from out_ready.
module fpu_skid_buf2
   import fpu_cvtsw_wb_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0]   state_q, state_d;
   logic [W-1:0] head_q, head_d;
   logic [W-1:0] skid_q, skid_d;
   logic         accept, retire;

   assign accept = in_valid & in_ready;
   assign retire = out_valid & out_ready;

   // NOTE: every next-state signal gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         BUF_EMPTY: begin
            if (accept) begin
               head_d  = in_data;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (accept && retire) begin
               head_d = in_data;
            end else if (accept) begin
               skid_d  = in_data;
               state_d = BUF_FULL;
            end else if (retire) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (retire) begin
               head_d  = skid_q;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   // NOTE: the data registers are reset too, because the head drives out_* and must read 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   assign out_valid = (state_q != BUF_EMPTY);
   assign in_ready  = (state_q != BUF_FULL);
   assign out_data  = head_q;

endmodule

// File: rtl/fpu_cvtsw_wb.sv
// Writeback stage behind the cvtsw converter: buffers results in a skid
// buffer and keeps the sticky NX/OF flags plus a saturating inexact count.
module fpu_cvtsw_wb
   import fpu_cvtsw_wb_pkg::*;
#(
   parameter int NEXP  = SGL_NEXP,
   parameter int NSIG  = SGL_NSIG,
   parameter int TAG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NEXP+NSIG:0]   in_s,
   input  logic                 in_inexact,
   input  logic                 in_overflow,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NEXP+NSIG:0]   out_s,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 out_nx,
   output logic                 out_of,
   output logic                 fflags_nx,
   output logic                 fflags_of,
   input  logic                 fflags_clr,
   output logic [CNT_W-1:0]     nx_count
);

   localparam int PW = NEXP + NSIG + 1 + TAG_W + 2;

   logic [PW-1:0]    in_payload, out_payload;
   logic             retire;
   logic             fflags_nx_q, fflags_nx_d;
   logic             fflags_of_q, fflags_of_d;
   logic [CNT_W-1:0] nx_count_q, nx_count_d;

   assign in_payload = {in_s, in_tag, in_inexact, in_overflow};

   fpu_skid_buf2 #(.W(PW)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_payload),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_payload)
   );

   assign {out_s, out_tag, out_nx, out_of} = out_payload;
   assign retire = out_valid & out_ready;

   // A retiring flag is OR-ed in after the clear, so set wins over clear.
   always_comb begin
      fflags_nx_d = (fflags_nx_q & ~fflags_clr) | (retire & out_nx);
      fflags_of_d = (fflags_of_q & ~fflags_clr) | (retire & out_of);
      nx_count_d  = nx_count_q;
      if (retire && out_nx && (nx_count_q != {CNT_W{1'b1}}))
         nx_count_d = nx_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fflags_nx_q <= 1'b0;
         fflags_of_q <= 1'b0;
         nx_count_q  <= '0;
      end else begin
         fflags_nx_q <= fflags_nx_d;
         fflags_of_q <= fflags_of_d;
         nx_count_q  <= nx_count_d;
      end
   end

   assign fflags_nx = fflags_nx_q;
   assign fflags_of = fflags_of_q;
   assign nx_count  = nx_count_q;

endmodule

// File: doc/fpu_cvtsw_wb.md
Name: fpu_cvtsw_wb

Overview:
- Registered writeback stage directly downstream of the combinational cvtsw integer-to-single converter.
- Captures the converter result `s` and its `inexact`/`overflow` flags under a valid/ready handshake.
- Buffers up to two results in a skid buffer so the converter path stays single-cycle under back-pressure.
- Accumulates sticky IEEE exception flags (NX, OF) and counts inexact conversions for the solver's status registers.

Parameters:
- NEXP, 8, exponent width of the result format.
- NSIG, 23, stored significand width of the result format.
- TAG_W, 5, width of the destination-register tag carried with each result.
- CNT_W, 16, width of the saturating inexact-event counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  converter result present this cycle.
- in_ready  out  1  stage can accept a result.
- in_s  in  NEXP+NSIG+1  converted float from cvtsw.
- in_inexact  in  1  cvtsw inexact flag.
- in_overflow  in  1  cvtsw overflow flag.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result available to the register file.
- out_ready  in  1  consumer accepts.
- out_s  out  NEXP+NSIG+1  head result.
- out_tag  out  TAG_W  head tag.
- out_nx  out  1  head inexact flag.
- out_of  out  1  head overflow flag.
- fflags_nx  out  1  sticky inexact.
- fflags_of  out  1  sticky overflow.
- fflags_clr  in  1  software clear of both sticky flags.
- nx_count  out  CNT_W  saturating count of retired inexact results.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state EMPTY; out_valid=0; in_ready=1.
  - out_s, out_tag, out_nx, out_of all 0.
  - fflags_nx=0, fflags_of=0, nx_count=0.
- Handshakes:
  - Accept = in_valid & in_ready.
  - Retire = out_valid & out_ready.
  - Both are evaluated on the same edge.
- Buffer: two entries, HEAD and SKID, each holding {s, tag, nx, of}. State machine:
  - EMPTY:
    - accept -> ONE (HEAD loaded).
    - otherwise stay.
  - ONE:
    - accept & retire -> ONE (HEAD replaced by new input).
    - accept only -> FULL (new input into SKID).
    - retire only -> EMPTY.
  - FULL:
    - retire -> ONE (SKID moves to HEAD).
    - no accept is possible in FULL.
- Output decoding:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL). It is a registered function of state, with no combinational path from out_ready.
  - out_* are driven directly from HEAD registers.
- Latency: result accepted on edge N is visible on out_* after edge N when the buffer was EMPTY. Throughput is one result per cycle while out_ready=1.
- Ordering: strict FIFO. No reordering or dropping.
- While out_valid=1 and out_ready=0, out_* hold stable.
- Sticky flags:
  - Updated on retire, not on accept: fflags_nx |= out_nx, fflags_of |= out_of.
  - fflags_clr clears both.
  - If a clear and a retire-set occur on the same edge, the set wins and the retired flag remains 1.
- nx_count:
  - Increments by 1 on each retire with out_nx=1.
  - Saturates at all-ones and never wraps.
  - Unaffected by fflags_clr; cleared only by reset.
- Zero results: in_s=0 with in_inexact=0 is passed through unchanged and sets no flag.
- Reset mid-operation: all buffered entries are discarded and no flag or count survives. The first accept after deassert behaves as from EMPTY.
- Arithmetic: pure pass-through of float bits. No rounding or reformatting in this stage.

Decomposition:
- Shared FPU package holds:
  - format constants: NEXP/NSIG pairs for single, BIAS, EMAX.
  - the flag-vector layout {NV, DZ, OF, UF, NX} used across all FPU writeback stages.
  - the buffer state encoding (EMPTY/ONE/FULL).
- One natural sub-module: fpu_skid_buf2, a generic 2-entry valid/ready skid buffer parameterized on payload width. It is reused by other FPU conversion stages.
- Flag and counter logic stays in the top module.

Test Plan:
- Single result: w=1 gives in_s=0x3F800000, nx=0, tag=3, out_ready=1 -> next cycle out_valid=1, out_s=0x3F800000, out_tag=3; fflags_nx stays 0; nx_count=0.
- Inexact accumulation: w=16777217 gives in_s=0x4B800000, nx=1 -> retire sets fflags_nx=1 and nx_count=1. A following w=-1 (0xBF800000, nx=0) leaves fflags_nx=1.
- Back-pressure: hold out_ready=0 and present three back-to-back inputs (tags 1,2,3) -> in_ready drops after the second accept and tag 3 is held off. Releasing out_ready yields tags 1,2,3 in order with no loss and no duplicates.
- Simultaneous accept/retire in ONE: continuous stream of 8 results with out_ready=1 -> one result per cycle, state stays ONE, in_ready=1 throughout.
- Clear vs set: fflags_clr=1 on the same edge as retiring an nx=1 result -> fflags_nx=1 afterwards. fflags_clr alone on a later cycle -> fflags_nx=0 while nx_count is unchanged.
- Saturation and reset:
  - With CNT_W=2, retire 5 inexact results -> nx_count=3.
  - Assert rst_n=0 mid-stream with two entries buffered -> immediately out_valid=0, in_ready=1, all flags and nx_count at 0.
